// File: rtl/regfile_pkg.sv
// Shared types and constants for the 2R1W register file.
// Init value depends on REGFILE_INIT_INDEX_EN (index pattern vs zero).
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_e;

  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;

  // Value loaded into reg[idx] by the post-reset sequencer.
  function automatic logic [31:0] rf_init_val(
    input logic [31:0] idx
  );
`ifdef REGFILE_INIT_INDEX_EN
    return idx;
`else
    return idx & 32'h0;
`endif
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset init sequencer: walks reg[1..NREG-1] then raises ready.
// Ports: clk_i, rst_i (async high) in; init_we_o/addr_o/data_o, ready_o out.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            init_we_o,
  output logic [AW-1:0]   init_addr_o,
  output logic [XLEN-1:0] init_data_o,
  output logic            ready_o
);

  // One extra bit so the terminal compare can never wrap.
  localparam logic [AW:0] LAST = (AW+1)'(NREG - 1);

  rf_state_e   state_q;
  logic [AW:0] cnt_q;
  logic        ready_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RF_INIT;
      cnt_q   <= (AW+1)'(1);
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        RF_INIT: begin
          cnt_q <= cnt_q + (AW+1)'(1);
          if (cnt_q == LAST) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN:  state_q <= RF_RUN;
        default: state_q <= RF_INIT;
      endcase
    end
  end

  assign init_we_o   = (state_q == RF_INIT);
  assign init_addr_o = cnt_q[AW-1:0];
  assign init_data_o = XLEN'(rf_init_val(32'(cnt_q)));
  assign ready_o     = ready_q;

endmodule

// File: rtl/regfile_2r1w_init.sv
// 2-read/1-write register file with hardwired x0, optional write bypass
// and a post-reset init sequence (init pattern: REGFILE_INIT_INDEX_EN).
// Ports: rs1_i/rs2_i + valid_src*_i -> val1_o/val2_o (combinational);
// rd_i/wen_i/wdata_i write on clk_i; ready_o high once init is done.
module regfile_2r1w_init
  import regfile_pkg::*;
#(
  parameter  int XLEN   = RF_XLEN,
  parameter  int NREG   = RF_NREG,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  input  logic            valid_src1_i,
  input  logic            valid_src2_i,
  output logic [XLEN-1:0] val1_o,
  output logic [XLEN-1:0] val2_o,
  input  logic [AW-1:0]   rd_i,
  input  logic            wen_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ready_o
);

  logic [XLEN-1:0] mem_q [NREG];

  logic            init_we;
  logic [AW-1:0]   init_addr;
  logic [XLEN-1:0] init_data;
  logic            ready;

  regfile_init_seq #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_seq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_data_o (init_data),
    .ready_o     (ready)
  );

  // External writes only count in RUN and never to x0.
  logic            ext_we;
  logic            we_d;
  logic [AW-1:0]   waddr_d;
  logic [XLEN-1:0] wdata_d;

  assign ext_we = ready & wen_i & (rd_i != '0);

  always_comb begin
    we_d    = init_we | ext_we;
    waddr_d = init_we ? init_addr : rd_i;
    wdata_d = init_we ? init_data : wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (we_d) mem_q[waddr_d] <= wdata_d;
  end

  logic [AW-1:0]   ra [2];
  logic [1:0]      rv;
  logic [XLEN-1:0] rdat [2];

  assign ra[0] = rs1_i;
  assign ra[1] = rs2_i;
  assign rv    = {valid_src2_i, valid_src1_i};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p] = '0;
      if (ready && rv[p] && ra[p] != '0) begin
        if (BYPASS != 0 && ext_we && rd_i == ra[p])
          rdat[p] = wdata_i;
        else
          rdat[p] = mem_q[ra[p]];
      end
    end
  end

  assign val1_o  = rdat[0];
  assign val2_o  = rdat[1];
  assign ready_o = ready;

endmodule

// File: tb/tb_regfile_2r1w_init.sv
// Directed bench for regfile_2r1w_init: default 32x32 bypass build and
// a 64-bit, 16-entry, no-bypass build; expectations go through a queue.
module tb_regfile_2r1w_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default build
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        v1, v2, wen;
  logic [31:0] wdata, val1, val2;
  logic        ready;

  regfile_2r1w_init u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .valid_src1_i (v1),
    .valid_src2_i (v2),
    .val1_o       (val1),
    .val2_o       (val2),
    .rd_i         (rd),
    .wen_i        (wen),
    .wdata_i      (wdata),
    .ready_o      (ready)
  );

  // wide build, no bypass
  logic        w_rst;
  logic [3:0]  w_rs1, w_rs2, w_rd;
  logic        w_v1, w_v2, w_wen;
  logic [63:0] w_wdata, w_val1, w_val2;
  logic        w_ready;

  regfile_2r1w_init #(
    .XLEN   (64),
    .NREG   (16),
    .BYPASS (0)
  ) u_w (
    .clk_i        (clk),
    .rst_i        (w_rst),
    .rs1_i        (w_rs1),
    .rs2_i        (w_rs2),
    .valid_src1_i (w_v1),
    .valid_src2_i (w_v2),
    .val1_o       (w_val1),
    .val2_o       (w_val2),
    .rd_i         (w_rd),
    .wen_i        (w_wen),
    .wdata_i      (w_wdata),
    .ready_o      (w_ready)
  );

  int checks = 0;
  int fails  = 0;

  logic [63:0] exp_q [$];
  string       tag_q [$];

  function automatic logic [63:0] iv(input int i);
`ifdef REGFILE_INIT_INDEX_EN
    return 64'(i);
`else
    return 64'(i) & 64'h0;
`endif
  endfunction

  task automatic push(input string t, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic chk(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL sb_empty observed=%h expected=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0;
    v1 = 1'b1; v2 = 1'b1; wen = 1'b0; wdata = '0;
    w_rst = 1'b1; w_rs1 = '0; w_rs2 = '0; w_rd = '0;
    w_v1 = 1'b1; w_v2 = 1'b1; w_wen = 1'b0; w_wdata = '0;

    step(); step();
    rs1 = 5'd5; rs2 = 5'd31;
    #1;
    push("rst_ready", 64'd0); chk(64'(ready));
    push("rst_val1", 64'd0);  chk(64'(val1));

    // release between edges, then count init edges
    #2 rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      push($sformatf("init_ready_e%0d", k), 64'(k == 31));
      chk(64'(ready));
      if (k == 10) begin
        push("init_val1_forced", 64'd0); chk(64'(val1));
        push("init_val2_forced", 64'd0); chk(64'(val2));
      end
    end

    push("run_rd5", iv(5));   chk(64'(val1));
    push("run_rd31", iv(31)); chk(64'(val2));

    // write with same-cycle bypass on both ports
    wen = 1'b1; rd = 5'd7; wdata = 32'hDEADBEEF;
    rs1 = 5'd7; rs2 = 5'd7;
    #1;
    push("byp_val1", 64'hDEADBEEF); chk(64'(val1));
    push("byp_val2", 64'hDEADBEEF); chk(64'(val2));
    step();
    wen = 1'b0;
    #1;
    push("wr7_val1", 64'hDEADBEEF); chk(64'(val1));
    push("wr7_val2", 64'hDEADBEEF); chk(64'(val2));

    // x0 write is discarded and never bypassed
    wen = 1'b1; rd = 5'd0; wdata = 32'hFFFFFFFF;
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    push("x0_same_val1", 64'd0); chk(64'(val1));
    step();
    wen = 1'b0;
    #1;
    push("x0_val1", 64'd0); chk(64'(val1));
    push("x0_val2", 64'd0); chk(64'(val2));

    // valid gating on register 9
    wen = 1'b1; rd = 5'd9; wdata = 32'h5A5A1234;
    step();
    wen = 1'b0;
    rs1 = 5'd9; rs2 = 5'd9; v1 = 1'b0; v2 = 1'b1;
    #1;
    push("gate_val1", 64'd0);          chk(64'(val1));
    push("gate_val2", 64'h5A5A1234);   chk(64'(val2));
    v1 = 1'b1;

    // async reset while in RUN
    rst = 1'b1;
    #1;
    push("run_rst_ready", 64'd0); chk(64'(ready));
    push("run_rst_val2", 64'd0);  chk(64'(val2));
    #2 rst = 1'b0;

    // reset again mid-INIT after 10 edges
    for (int k = 1; k <= 10; k++) step();
    rst = 1'b1;
    #1;
    push("mid_rst_ready", 64'd0); chk(64'(ready));
    #2 rst = 1'b0;

    // write during INIT must be lost
    wen = 1'b1; rd = 5'd3; wdata = 32'h000000AA;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k >= 30) begin
        push($sformatf("reinit_ready_e%0d", k), 64'(k == 31));
        chk(64'(ready));
      end
    end
    wen = 1'b0;
    rs1 = 5'd3; rs2 = 5'd7;
    #1;
    push("reinit_rd3", iv(3)); chk(64'(val1));
    push("reinit_rd7", iv(7)); chk(64'(val2));
    rs1 = 5'd9;
    #1;
    push("reinit_rd9", iv(9)); chk(64'(val1));

    // wide, no-bypass build
    #2 w_rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k >= 14) begin
        push($sformatf("w_ready_e%0d", k), 64'(k == 15));
        chk(64'(w_ready));
      end
    end
    w_wen = 1'b1; w_rd = 4'd15; w_wdata = 64'h123456789ABCDEF0;
    w_rs1 = 4'd15; w_rs2 = 4'd15;
    #1;
    push("w_same_val1", iv(15)); chk(w_val1);
    push("w_same_val2", iv(15)); chk(w_val2);
    step();
    w_wen = 1'b0;
    #1;
    push("w_val1", 64'h123456789ABCDEF0); chk(w_val1);
    push("w_val2", 64'h123456789ABCDEF0); chk(w_val2);
    w_rs1 = 4'd6;
    #1;
    push("w_rd6", iv(6)); chk(w_val1);

    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_init.md
Name: regfile_2r1w_init

Overview:
- Parametrised successor to the current read-only register file.
- Adds a synchronous write port, hardwired x0, a write-to-read bypass, and a post-reset init sequencer that loads every register before the core may use the file.
- Sits between decode (rs1/rs2 lookup) and writeback (rd commit) in the single-cycle RISC-V datapath.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- NREG, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREG), register address width (derived; do not override).
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to the read output; 0 = the write becomes visible on the next cycle.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- rs1_i  input  AW  read address, port 1.
- rs2_i  input  AW  read address, port 2.
- valid_src1_i  input  1  port 1 read enable.
- valid_src2_i  input  1  port 2 read enable.
- val1_o  output  XLEN  port 1 read data.
- val2_o  output  XLEN  port 2 read data.
- rd_i  input  AW  write address.
- wen_i  input  1  write enable.
- wdata_i  input  XLEN  write data.
- ready_o  output  1  high once initialisation has finished; writes are accepted and reads are valid only while it is high.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - FSM goes to INIT; init counter cnt goes to 1; ready_o=0.
  - Array contents are not reset directly; the sequencer rewrites them.
- FSM states INIT and RUN:
  - INIT: each rising edge writes the init value to reg[cnt], then cnt increments. The edge that writes reg[NREG-1] moves the FSM to RUN.
  - Total init time is NREG-1 edges after reset release; ready_o=1 from that edge on (31 edges at default).
  - RUN: stays in RUN until the next reset.
- Init value: zero (see Optional Feature for the alternative).
- Reset asserted mid-INIT or in RUN: the sequence restarts from cnt=1; partially written contents are overwritten.
- During INIT:
  - wen_i is ignored.
  - val1_o and val2_o are forced to 0 whatever the valid inputs.
- Reads in RUN (combinational, zero latency):
  - valid_srcN_i=0 -> valN_o=0.
  - rsN_i=0 -> 0.
  - BYPASS=1, wen_i=1, rd_i=rsN_i!=0 -> wdata_i.
  - otherwise -> reg[rsN_i].
- Writes in RUN:
  - wen_i=1 and rd_i!=0 -> reg[rd_i]<=wdata_i on the rising edge.
  - rd_i=0 -> write discarded; x0 always reads 0.
- Both read ports may address the same register, including the register being written in that cycle; both get the identical value.
- BYPASS=0: a read in the same cycle as the write returns the old value; the new value is visible from the following cycle.
- Counter width is AW+1 so the terminal compare never wraps. Storage is exactly XLEN bits per entry; no truncation anywhere.

Optional Feature:
- Macro: REGFILE_INIT_INDEX_EN.
- Defined: the INIT sequencer writes reg[i]=i, zero-extended to XLEN. This gives a known non-zero pattern for bring-up and directed tests.
- Undefined: the INIT sequencer writes 0 to every register.
- x0 reads 0 in both builds.

Decomposition:
- Package regfile_pkg holds:
  - the FSM state enum {RF_INIT, RF_RUN};
  - default constants RF_XLEN=32 and RF_NREG=32;
  - a function producing the init value for index i.
- One sub-module is natural: regfile_init_seq. It contains the FSM and counter, and outputs init_we, init_addr, init_data and ready.
- The top level muxes the write source (init versus external) and implements the read, bypass and x0 logic.

Test Plan:
- Reset release with REGFILE_INIT_INDEX_EN defined: ready_o=0 for 31 edges and 1 after the 31st. Then rs1=5, rs2=31 with both valids high -> val1=5, val2=31.
- Write in RUN: wen=1, rd=7, wdata=0xDEADBEEF. Same cycle, rs1=7 -> 0xDEADBEEF with BYPASS=1, or the old value with BYPASS=0. Next cycle -> 0xDEADBEEF in both cases.
- x0 write: wen=1, rd=0, wdata=0xFFFFFFFF. Next cycle rs1=0, rs2=0 -> both 0.
- Valid gating: rs1=rs2=9 with valid_src1=0 and valid_src2=1 -> val1=0, val2=register 9 contents.
- Reset mid-INIT: assert rst_i asynchronously at edge 10. ready_o drops immediately; after release it takes a full 31 more edges before ready_o=1. A write attempted during INIT (rd=3, wdata=0xAA) is lost, and reg3 reads its init value.
- Parametrised build XLEN=64, NREG=16: init takes 15 edges. Writing 0x123456789ABCDEF0 to reg15 reads back the full 64 bits.
